// File: rtl/shutter_seq_ctrl_pkg.sv
// Shared definitions for the shutter sequencer and the parameter parser.
// Holds the shutter status codes, the sequencer state encoding and a helper
// for the unsigned temperature drift magnitude.
package shutter_seq_ctrl_pkg;

  // Status codes seen by the parameter parser. 2'b00 and 2'b11 are never used.
  localparam logic [1:0] SHUTTER_OPEN = 2'b01;
  localparam logic [1:0] SHUTTER_CLOS = 2'b10;

  // Sequencer state encoding (plain constants so legacy tools can decode them).
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE         = 3'd0;
  localparam state_t ST_CLOSE_DRV    = 3'd1;
  localparam state_t ST_CLOSE_SETTLE = 3'd2;
  localparam state_t ST_CALC         = 3'd3;
  localparam state_t ST_OPEN_DRV     = 3'd4;
  localparam state_t ST_OPEN_SETTLE  = 3'd5;

  // |a - b| for unsigned 16-bit inputs, computed in 17 bits so it never wraps.
  function automatic logic [16:0] abs_diff17(input logic [15:0] a,
                                             input logic [15:0] b);
    logic [16:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[16] ? (17'd0 - d) : d;
  endfunction

endpackage

// File: rtl/shutter_seq_ctrl_trig.sv
// shutter_trig_gen: collects calibration requests into a single pending flag.
// Sources: manual pulse, periodic timer (counts IDLE cycles while enabled)
// and shutter temperature drift (checked only while IDLE).
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   i_cal_req               manual request pulse
//   i_auto_en               enables periodic and drift triggers
//   i_temp_shutter(_pre)    current / last-close shutter temperature
//   i_idle                  sequencer is in IDLE
//   i_seq_start             sequencer leaves IDLE this cycle (consumes pending)
//   i_seq_done              sequencer finishes OPEN_SETTLE this cycle
//   o_trig                  registered pending flag
module shutter_trig_gen
  import shutter_seq_ctrl_pkg::*;
#(
  parameter logic [31:0] AUTO_PERIOD = 32'd0,
  parameter logic [15:0] TEMP_DELTA  = 16'd64,
  parameter logic        POWERON_CAL = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cal_req,
  input  logic        i_auto_en,
  input  logic [15:0] i_temp_shutter,
  input  logic [15:0] i_temp_shutter_pre,
  input  logic        i_idle,
  input  logic        i_seq_start,
  input  logic        i_seq_done,
  output logic        o_trig
);

  localparam logic        PERIOD_EN = (AUTO_PERIOD != 32'd0);
  localparam logic [31:0] PER_LAST  = AUTO_PERIOD - 32'd1;

  logic [31:0] per_q, per_d;
  logic        pending_q, pending_d;
  logic [16:0] drift;
  logic        drift_hit, period_hit;

  always_comb begin
    drift = abs_diff17(i_temp_shutter, i_temp_shutter_pre);
    // Level-type triggers are masked while a request is already pending so a
    // condition that is still present on the IDLE exit cycle does not arm a
    // second back-to-back sequence. Manual pulses are always retained.
    drift_hit  = i_auto_en && i_idle && !pending_q &&
                 (drift >= {1'b0, TEMP_DELTA});
    period_hit = i_auto_en && PERIOD_EN && !pending_q && (per_q == PER_LAST);

    per_d = per_q;
    if (i_seq_start || i_seq_done) begin
      per_d = '0;
    end else if (i_idle && i_auto_en && PERIOD_EN && (per_q != PER_LAST)) begin
      per_d = per_q + 32'd1;  // saturates at PER_LAST until the sequence starts
    end

    pending_d = (pending_q && !i_seq_start) || i_cal_req || period_hit || drift_hit;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      per_q     <= '0;
      pending_q <= POWERON_CAL;
    end else begin
      per_q     <= per_d;
      pending_q <= pending_d;
    end
  end

  assign o_trig = pending_q;

endmodule

// File: rtl/shutter_seq_ctrl.sv
// shutter_seq_ctrl: close -> settle -> calibrate -> open shutter sequencer.
// Ports:
//   i_clk, i_rst         clock, async active-high reset
//   i_cal_req            manual calibration request pulse
//   i_auto_en            enables periodic and drift triggers
//   i_temp_shutter(_pre) current / last-close shutter temperature
//   i_calc_b_done        B-calibration complete pulse (honoured only in CALC)
//   o_shutter            status code (SHUTTER_OPEN / SHUTTER_CLOS)
//   o_motor_close/open   coil drives, never both high
//   o_calc_b_start       one-cycle start pulse on CALC entry
//   o_busy               high in every state except IDLE
//   o_timeout            one-cycle pulse when the calibration wait expired
//   o_cal_cnt            completed sequences, wraps
//   o_state              current FSM state (debug)
// Calibration handshake: o_calc_b_start pulses for the first CALC cycle; the
// engine answers with a one-cycle i_calc_b_done at any later or same cycle
// while in CALC. Done on the timeout cycle wins over the timeout.
// All outputs are registered, decoded from the next state.
module shutter_seq_ctrl
  import shutter_seq_ctrl_pkg::*;
#(
  parameter logic [15:0] DRIVE_CYCLES  = 16'd2000,
  parameter logic [15:0] SETTLE_CYCLES = 16'd1000,
  parameter logic [23:0] CALC_TIMEOUT  = 24'd1_000_000,
  parameter logic [31:0] AUTO_PERIOD   = 32'd0,
  parameter logic [15:0] TEMP_DELTA    = 16'd64,
  parameter logic        POWERON_CAL   = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cal_req,
  input  logic        i_auto_en,
  input  logic [15:0] i_temp_shutter,
  input  logic [15:0] i_temp_shutter_pre,
  input  logic        i_calc_b_done,
  output logic [1:0]  o_shutter,
  output logic        o_motor_close,
  output logic        o_motor_open,
  output logic        o_calc_b_start,
  output logic        o_busy,
  output logic        o_timeout,
  output logic [7:0]  o_cal_cnt,
  output logic [2:0]  o_state
);

  localparam logic [23:0] DRV_LAST = {8'd0, DRIVE_CYCLES} - 24'd1;
  localparam logic [23:0] SET_LAST = {8'd0, SETTLE_CYCLES} - 24'd1;
  localparam logic [23:0] TMO_LAST = CALC_TIMEOUT - 24'd1;

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  cal_cnt_q, cal_cnt_d;
  logic [1:0]  shutter_q, shutter_d;
  logic        mclose_q, mopen_q, start_q, busy_q, timeout_q;
  logic        start_d, timeout_d;
  logic        trig, seq_start, seq_done;

  shutter_trig_gen #(
    .AUTO_PERIOD (AUTO_PERIOD),
    .TEMP_DELTA  (TEMP_DELTA),
    .POWERON_CAL (POWERON_CAL)
  ) u_trig (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_cal_req          (i_cal_req),
    .i_auto_en          (i_auto_en),
    .i_temp_shutter     (i_temp_shutter),
    .i_temp_shutter_pre (i_temp_shutter_pre),
    .i_idle             (state_q == ST_IDLE),
    .i_seq_start        (seq_start),
    .i_seq_done         (seq_done),
    .o_trig             (trig)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 24'd1;
    cal_cnt_d = cal_cnt_q;
    start_d   = 1'b0;
    timeout_d = 1'b0;
    seq_start = 1'b0;
    seq_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (trig) begin
          state_d   = ST_CLOSE_DRV;
          seq_start = 1'b1;
        end
      end
      ST_CLOSE_DRV: begin
        if (cnt_q == DRV_LAST) begin
          state_d = ST_CLOSE_SETTLE;
          cnt_d   = '0;
        end
      end
      ST_CLOSE_SETTLE: begin
        if (cnt_q == SET_LAST) begin
          state_d = ST_CALC;
          cnt_d   = '0;
          start_d = 1'b1;
        end
      end
      ST_CALC: begin
        if (i_calc_b_done) begin
          state_d = ST_OPEN_DRV;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d   = ST_OPEN_DRV;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end
      end
      ST_OPEN_DRV: begin
        if (cnt_q == DRV_LAST) begin
          state_d = ST_OPEN_SETTLE;
          cnt_d   = '0;
        end
      end
      ST_OPEN_SETTLE: begin
        if (cnt_q == SET_LAST) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          cal_cnt_d = cal_cnt_q + 8'd1;
          seq_done  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    shutter_d = ((state_d == ST_CLOSE_DRV) || (state_d == ST_CLOSE_SETTLE) ||
                 (state_d == ST_CALC)) ? SHUTTER_CLOS : SHUTTER_OPEN;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cal_cnt_q <= '0;
      shutter_q <= SHUTTER_OPEN;
      mclose_q  <= 1'b0;
      mopen_q   <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cal_cnt_q <= cal_cnt_d;
      shutter_q <= shutter_d;
      mclose_q  <= (state_d == ST_CLOSE_DRV);
      mopen_q   <= (state_d == ST_OPEN_DRV);
      start_q   <= start_d;
      busy_q    <= (state_d != ST_IDLE);
      timeout_q <= timeout_d;
    end
  end

  assign o_shutter      = shutter_q;
  assign o_motor_close  = mclose_q;
  assign o_motor_open   = mopen_q;
  assign o_calc_b_start = start_q;
  assign o_busy         = busy_q;
  assign o_timeout      = timeout_q;
  assign o_cal_cnt      = cal_cnt_q;
  assign o_state        = state_q;

endmodule

// File: tb/tb_shutter_seq_ctrl.sv
// Bench for shutter_seq_ctrl. dut_a: AUTO_PERIOD=0, POWERON_CAL=1.
// dut_b: AUTO_PERIOD=50, POWERON_CAL=0, calibration done tied to its start.
module tb_shutter_seq_ctrl;

  localparam logic [1:0] SH_OPEN = 2'b01;
  localparam logic [1:0] SH_CLOS = 2'b10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A ----------------
  logic        req_a = 1'b0, auto_a = 1'b0, done_a = 1'b0;
  logic [15:0] temp_a = 16'd1000, pre_a = 16'd1000;
  logic [1:0]  shutter_a;
  logic        mclose_a, mopen_a, start_a, busy_a, timeout_a;
  logic [7:0]  cnt_a;
  logic [2:0]  state_a;

  shutter_seq_ctrl #(
    .DRIVE_CYCLES(16'd4), .SETTLE_CYCLES(16'd3), .CALC_TIMEOUT(24'd20),
    .AUTO_PERIOD(32'd0), .TEMP_DELTA(16'd64), .POWERON_CAL(1'b1)
  ) dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_cal_req(req_a), .i_auto_en(auto_a),
    .i_temp_shutter(temp_a), .i_temp_shutter_pre(pre_a), .i_calc_b_done(done_a),
    .o_shutter(shutter_a), .o_motor_close(mclose_a), .o_motor_open(mopen_a),
    .o_calc_b_start(start_a), .o_busy(busy_a), .o_timeout(timeout_a),
    .o_cal_cnt(cnt_a), .o_state(state_a)
  );

  // ---------------- DUT B ----------------
  logic        auto_b = 1'b0;
  logic [1:0]  shutter_b;
  logic        mclose_b, mopen_b, start_b, busy_b, timeout_b;
  logic [7:0]  cnt_b;
  logic [2:0]  state_b;

  shutter_seq_ctrl #(
    .DRIVE_CYCLES(16'd4), .SETTLE_CYCLES(16'd3), .CALC_TIMEOUT(24'd20),
    .AUTO_PERIOD(32'd50), .TEMP_DELTA(16'd64), .POWERON_CAL(1'b0)
  ) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_cal_req(1'b0), .i_auto_en(auto_b),
    .i_temp_shutter(16'd0), .i_temp_shutter_pre(16'd0), .i_calc_b_done(start_b),
    .o_shutter(shutter_b), .o_motor_close(mclose_b), .o_motor_open(mopen_b),
    .o_calc_b_start(start_b), .o_busy(busy_b), .o_timeout(timeout_b),
    .o_cal_cnt(cnt_b), .o_state(state_b)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];      // one record per expected DUT A sequence
  logic [15:0] exp_gap_q[$];  // DUT B idle-cycle run before each start

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Record layout: close | gap | calc | to_n(4) | to_off | open | settle | cnt | starts(4)
  function automatic logic [63:0] mk(input int close_len, input int gap, input int calc,
                                     input int to_n, input int to_off, input int open_len,
                                     input int settle, input int cnt, input int starts);
    return {8'(close_len), 8'(gap), 8'(calc), 4'(to_n), 8'(to_off),
            8'(open_len), 8'(settle), 8'(cnt), 4'(starts)};
  endfunction

  // ---------------- monitor A ----------------
  int   m_close, m_gap, m_calc, m_to_n, m_to_off, m_open, m_settle, m_starts, m_since;
  bit   m_in = 0, m_start_seen, m_bad;
  logic prev_busy_a = 1'b0;
  int   idle_bad = 0;

  always @(negedge clk) begin
    if (rst_a) begin
      m_in = 0;
      prev_busy_a = 1'b0;
    end else begin
      if (!busy_a && (shutter_a !== SH_OPEN || mclose_a || mopen_a)) idle_bad++;
      if (busy_a && !prev_busy_a) begin
        chk("start_expected", 32'(exp_q.size() > 0), 32'd1);
        m_in = 1; m_close = 0; m_gap = 0; m_calc = 0; m_to_n = 0; m_to_off = 0;
        m_open = 0; m_settle = 0; m_starts = 0; m_since = 0;
        m_start_seen = 0; m_bad = 0;
      end
      if (m_in) begin
        if (mclose_a) m_close++;
        if (m_close > 0 && !mclose_a && !m_start_seen && !start_a) m_gap++;
        if (start_a) begin
          m_starts++; m_start_seen = 1; m_since = 0;
        end else if (m_start_seen) m_since++;
        if (m_start_seen && shutter_a == SH_CLOS) m_calc++;
        if (timeout_a) begin m_to_n++; m_to_off = m_since; end
        if (mopen_a) m_open++;
        if (m_open > 0 && !mopen_a && busy_a) m_settle++;
        if (shutter_a != SH_OPEN && shutter_a != SH_CLOS) m_bad = 1;
        if (mclose_a && mopen_a) m_bad = 1;
        if (mclose_a && shutter_a != SH_CLOS) m_bad = 1;
        if (mopen_a && shutter_a != SH_OPEN) m_bad = 1;
        if (m_close > 0 && m_open == 0 && !mopen_a && shutter_a != SH_CLOS) m_bad = 1;
      end
      if (!busy_a && prev_busy_a && m_in) begin
        if (exp_q.size() > 0) begin
          logic [63:0] e;
          e = exp_q.pop_front();
          chk("close_len",    m_close,   32'(e[63:56]));
          chk("close_to_start", m_gap,   32'(e[55:48]));
          chk("calc_len",     m_calc,    32'(e[47:40]));
          chk("timeout_cnt",  m_to_n,    32'(e[39:36]));
          chk("timeout_off",  m_to_off,  32'(e[35:28]));
          chk("open_len",     m_open,    32'(e[27:20]));
          chk("open_settle",  m_settle,  32'(e[19:12]));
          chk("cal_cnt",      32'(cnt_a), 32'(e[11:4]));
          chk("start_pulses", m_starts,  32'(e[3:0]));
          chk("codes_ok",     32'(m_bad), 32'd0);
        end
        m_in = 0;
      end
      prev_busy_a = busy_a;
    end
  end

  // ---------------- monitor B ----------------
  logic prev_busy_b = 1'b0;
  bit   seen_fall_b = 0;
  int   run_b = 0, falls_b = 0, rises_b = 0;

  always @(negedge clk) begin
    if (rst_b) begin
      prev_busy_b = 1'b0; seen_fall_b = 0; run_b = 0;
    end else begin
      if (busy_b && !prev_busy_b) begin
        rises_b++;
        if (seen_fall_b) begin
          if (exp_gap_q.size() > 0) chk("period_gap", run_b, 32'(exp_gap_q.pop_front()));
          else begin
            checks++; errors++;
            $display("FAIL period_gap: unexpected start after %0d idle cycles", run_b);
          end
        end
      end
      if (!busy_b && prev_busy_b) begin falls_b++; seen_fall_b = 1; run_b = 0; end
      if (!busy_b) run_b++;
      prev_busy_b = busy_b;
    end
  end

  // ---------------- calibration engine model for DUT A ----------------
  bit resp_mode = 1;  // 1: answer done 5 cycles after start, 0: never answer
  initial begin
    forever begin
      @(negedge clk);
      if (start_a && resp_mode) begin
        repeat (5) @(negedge clk);
        done_a = 1'b1;
        @(negedge clk);
        done_a = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_req();
    @(negedge clk); req_a = 1'b1;
    @(negedge clk); req_a = 1'b0;
  endtask

  task automatic wait_exp_empty(input string name, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin @(negedge clk); n++; end
    chk(name, exp_q.size(), 32'd0);
  endtask

  task automatic drift_case(input logic [15:0] pre_val, input int cnt);
    exp_q.push_back(mk(4, 3, 6, 0, 0, 4, 3, cnt, 1));
    pre_a = pre_val;
    repeat (2) @(negedge clk);
    chk("drift_start_2cyc", 32'(busy_a), 32'd1);
    pre_a = 16'd1000;
    wait_exp_empty("drift_seq_done", 200);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_shutter", 32'(shutter_a), 32'(SH_OPEN));
    chk("rst_motors",  32'({mclose_a, mopen_a}), 32'd0);
    chk("rst_busy",    32'(busy_a), 32'd0);
    chk("rst_start",   32'(start_a), 32'd0);
    chk("rst_timeout", 32'(timeout_a), 32'd0);
    chk("rst_cal_cnt", 32'(cnt_a), 32'd0);

    // Power-on sequence, done answered after 5 CALC cycles.
    exp_q.push_back(mk(4, 3, 6, 0, 0, 4, 3, 1, 1));
    rst_a = 1'b0;
    rst_b = 1'b0;
    wait_exp_empty("poweron_seq_done", 200);
    repeat (5) @(negedge clk);
    chk("idle_after_poweron", 32'(busy_a), 32'd0);

    // Calibration engine never answers: timeout path.
    resp_mode = 0;
    exp_q.push_back(mk(4, 3, 20, 1, 20, 4, 3, 2, 1));
    pulse_req();
    wait_exp_empty("timeout_seq_done", 200);
    resp_mode = 1;
    repeat (5) @(negedge clk);

    // Three requests while busy collapse into one follow-up.
    exp_q.push_back(mk(4, 3, 6, 0, 0, 4, 3, 3, 1));
    exp_q.push_back(mk(4, 3, 6, 0, 0, 4, 3, 4, 1));
    pulse_req();
    repeat (3) begin repeat (3) @(negedge clk); pulse_req(); end
    wait_exp_empty("collapse_seq_done", 300);
    repeat (30) @(negedge clk);
    chk("collapse_no_extra", 32'(cnt_a), 32'd4);

    // Drift threshold boundaries.
    auto_a = 1'b1;
    pre_a = 16'd937;
    repeat (20) @(negedge clk);
    chk("drift63_no_trig", 32'(busy_a), 32'd0);
    drift_case(16'd936, 5);
    pre_a = 16'd1063;
    repeat (20) @(negedge clk);
    chk("drift63_up_no_trig", 32'(busy_a), 32'd0);
    drift_case(16'd1064, 6);
    auto_a = 1'b0;
    repeat (5) @(negedge clk);

    // Reset in the middle of CALC.
    exp_q.push_back(mk(4, 3, 6, 0, 0, 4, 3, 7, 1));
    pulse_req();
    n = 0;
    while (!start_a && n < 100) begin @(negedge clk); n++; end
    chk("calc_entered", 32'(start_a), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_a = 1'b1;
    #1;
    chk("midrst_shutter", 32'(shutter_a), 32'(SH_OPEN));
    chk("midrst_motors",  32'({mclose_a, mopen_a}), 32'd0);
    chk("midrst_busy",    32'(busy_a), 32'd0);
    chk("midrst_cal_cnt", 32'(cnt_a), 32'd0);
    void'(exp_q.pop_front());
    exp_q.push_back(mk(4, 3, 6, 0, 0, 4, 3, 1, 1));
    @(negedge clk);
    @(negedge clk);
    #2 rst_a = 1'b0;
    wait_exp_empty("restart_seq_done", 200);

    // Periodic trigger on DUT B: 50 counted cycles plus one pending cycle.
    exp_gap_q.push_back(16'd51);
    exp_gap_q.push_back(16'd51);
    auto_b = 1'b1;
    n = 0;
    while (falls_b < 3 && n < 400) begin @(negedge clk); n++; end
    chk("period_three_seqs", falls_b, 32'd3);
    exp_gap_q.push_back(16'd81);
    repeat (10) @(negedge clk);
    auto_b = 1'b0;
    repeat (30) @(negedge clk);
    auto_b = 1'b1;
    n = 0;
    while (rises_b < 4 && n < 200) begin @(negedge clk); n++; end
    chk("period_fourth_start", rises_b, 32'd4);
    auto_b = 1'b0;
    repeat (30) @(negedge clk);

    chk("exp_q_drained",   exp_q.size(), 32'd0);
    chk("gap_q_drained",   exp_gap_q.size(), 32'd0);
    chk("idle_outputs_ok", idle_bad, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
